// File: rtl/stc_pkg.sv
// Shared constants, detection record and FSM encoding for the STC target detector.
// The optional det_width field is present when STC_DET_WIDTH_EN is defined.
package stc_pkg;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned RANGE_W     = 12;
  localparam int unsigned RANGE_LIMIT = 4095;
  localparam int unsigned RUN_W       = 4;
  localparam int unsigned RUN_MAX     = 15;

  typedef struct packed {
    logic [RANGE_W-1:0] range;
    logic [DATA_W-1:0]  peak;
`ifdef STC_DET_WIDTH_EN
    logic [RUN_W-1:0]   width;
`endif
  } det_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/stc_det_fifo.sv
// Synchronous detection FIFO with a registered head; push and pop may coincide,
// a push into a full FIFO without a pop is dropped and flagged on o_drop_c.
module stc_det_fifo
  import stc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  det_t i_data,
  input  logic i_pop,
  output logic o_valid,
  output det_t o_head,
  output logic o_drop_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  det_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  det_t          r_head;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_nxt;
  logic [CW-1:0] w_after_pop;
  logic [CW-1:0] w_count_nxt;

  // Accept/drop decisions and next occupancy
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_pop       = i_pop && !w_empty;
    w_push      = i_push && (!w_full || w_pop);
    w_rd_nxt    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    w_after_pop = r_count - CW'(w_pop);
    w_count_nxt = w_after_pop + CW'(w_push);
    o_drop_c    = i_push && w_full && !w_pop;
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers, count and registered head; head holds while the FIFO is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_head <= (w_after_pop == '0) ? i_data : r_mem[w_rd_nxt];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/stc_target_detector.sv
// Per-sweep threshold detector: range counter, threshold latch, run tracker and
// detection FIFO. Define STC_DET_WIDTH_EN to add the det_width output.
module stc_target_detector
  import stc_pkg::*;
#(
  parameter int unsigned MIN_RUN    = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic [DATA_W-1:0]  vid_in,
  input  logic [DATA_W-1:0]  threshold,
  output logic               det_valid,
  input  logic               det_ready,
  output logic [RANGE_W-1:0] det_range,
  output logic [DATA_W-1:0]  det_peak,
  output logic               overflow,
  output logic               sweep_done
`ifdef STC_DET_WIDTH_EN
  ,
  output logic [RUN_W-1:0]   det_width
`endif
);

  state_t             r_state, w_state_nxt;
  logic [RANGE_W-1:0] r_range, w_range_nxt;
  logic [DATA_W-1:0]  r_thr, w_thr_nxt;
  logic               r_open, w_open_nxt;
  logic [RUN_W-1:0]   r_len, w_len_nxt;
  logic [DATA_W-1:0]  r_peak, w_peak_nxt;
  logic [RANGE_W-1:0] r_prange, w_prange_nxt;
  logic               r_push, w_push_nxt;
  det_t               r_push_data, w_push_data;
  logic               r_overflow;
  logic               r_sweep_done;
  logic               w_clr_ovf;
  logic               w_above;
  logic               w_last;
  logic               w_drop;
  det_t               w_head;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, range counter and run tracking
  always_comb begin
    w_state_nxt  = r_state;
    w_range_nxt  = r_range;
    w_thr_nxt    = r_thr;
    w_open_nxt   = r_open;
    w_len_nxt    = r_len;
    w_peak_nxt   = r_peak;
    w_prange_nxt = r_prange;
    w_push_nxt   = 1'b0;
    w_push_data  = r_push_data;
    w_clr_ovf    = 1'b0;
    w_above      = (vid_in >= r_thr);
    w_last       = (r_range == RANGE_W'(RANGE_LIMIT));
    if (trig) begin
      w_state_nxt  = ST_SWEEP;
      w_range_nxt  = '0;
      w_thr_nxt    = threshold;
      w_open_nxt   = 1'b0;
      w_len_nxt    = '0;
      w_clr_ovf    = 1'b1;
    end else if (r_state == ST_SWEEP) begin
      if (w_above) begin
        if (r_open) begin
          if (r_len != RUN_W'(RUN_MAX)) w_len_nxt = r_len + RUN_W'(1);
          if (vid_in > r_peak) begin
            w_peak_nxt   = vid_in;
            w_prange_nxt = r_range;
          end
        end else begin
          w_open_nxt   = 1'b1;
          w_len_nxt    = RUN_W'(1);
          w_peak_nxt   = vid_in;
          w_prange_nxt = r_range;
        end
      end
      // Close on the first sub-threshold sample or at the end of the sweep
      if ((r_open && !w_above) || (w_last && w_open_nxt)) begin
        w_push_nxt        = (w_len_nxt >= RUN_W'(MIN_RUN));
        w_push_data.range = w_prange_nxt;
        w_push_data.peak  = w_peak_nxt;
`ifdef STC_DET_WIDTH_EN
        w_push_data.width = w_len_nxt;
`endif
        w_open_nxt = 1'b0;
        w_len_nxt  = '0;
      end
      if (w_last) w_state_nxt = ST_DONE;
      else        w_range_nxt = r_range + RANGE_W'(1);
    end
  end

  // Datapath registers, sticky overflow and sweep_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_range      <= '0;
      r_thr        <= '0;
      r_open       <= 1'b0;
      r_len        <= '0;
      r_peak       <= '0;
      r_prange     <= '0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_overflow   <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_range      <= w_range_nxt;
      r_thr        <= w_thr_nxt;
      r_open       <= w_open_nxt;
      r_len        <= w_len_nxt;
      r_peak       <= w_peak_nxt;
      r_prange     <= w_prange_nxt;
      r_push       <= w_push_nxt;
      r_push_data  <= w_push_data;
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_clr_ovf) r_overflow <= 1'b0;
      r_sweep_done <= (w_state_nxt == ST_DONE);
    end
  end

  stc_det_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (r_push),
    .i_data   (r_push_data),
    .i_pop    (det_ready),
    .o_valid  (det_valid),
    .o_head   (w_head),
    .o_drop_c (w_drop)
  );

  assign det_range  = w_head.range;
  assign det_peak   = w_head.peak;
  assign overflow   = r_overflow;
  assign sweep_done = r_sweep_done;
`ifdef STC_DET_WIDTH_EN
  assign det_width  = w_head.width;
`endif

endmodule

// File: tb/tb_stc_target_detector.sv
// Directed bench for stc_target_detector; width checks run when STC_DET_WIDTH_EN is defined.
module tb_stc_target_detector;
  import stc_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               trig;
  logic [DATA_W-1:0]  vid_in;
  logic [DATA_W-1:0]  threshold;
  logic               det_valid;
  logic               det_ready;
  logic [RANGE_W-1:0] det_range;
  logic [DATA_W-1:0]  det_peak;
  logic               overflow;
  logic               sweep_done;
`ifdef STC_DET_WIDTH_EN
  logic [RUN_W-1:0]   det_width;
`endif

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  stc_target_detector #(.MIN_RUN(2), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .vid_in     (vid_in),
    .threshold  (threshold),
    .det_valid  (det_valid),
    .det_ready  (det_ready),
    .det_range  (det_range),
    .det_peak   (det_peak),
    .overflow   (overflow),
    .sweep_done (sweep_done)
`ifdef STC_DET_WIDTH_EN
    ,
    .det_width  (det_width)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic send(input int v);
    vid_in = DATA_W'(v);
    tick();
  endtask

  task automatic idle_to(input int r);
    while (cur < r) send(0);
  endtask

  task automatic trig_pulse(input int thr);
    trig      = 1'b1;
    threshold = DATA_W'(thr);
    vid_in    = '0;
    tick();
    trig = 1'b0;
    cur  = 0;
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; vid_in = '0; threshold = '0; det_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(det_valid), 0);
    check("rst_range", 32'(det_range), 0);
    check("rst_peak", 32'(det_peak), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_done", 32'(sweep_done), 0);
    rst = 1'b0;
    tick();

    // 1: run of 150 at 10..14, closing sample at 15
    trig_pulse(100);
    idle_to(10);
    repeat (5) send(150);
    send(0);
    check("t1_valid_lat1", 32'(det_valid), 0);
    send(0);
    check("t1_valid_lat2", 32'(det_valid), 1);
    check("t1_range", 32'(det_range), 10);
    check("t1_peak", 32'(det_peak), 150);
    det_ready = 1'b1; send(0); det_ready = 1'b0;
    check("t1_popped", 32'(det_valid), 0);
    check("t1_hold_range", 32'(det_range), 10);

    // 2: single-sample spike dropped, 200/300/250 reported at 61
    idle_to(50);
    send(4000);
    send(0); send(0); send(0);
    check("t2_spike", 32'(det_valid), 0);
    idle_to(60);
    send(200); send(300); send(250); send(0); send(0);
    check("t2_valid", 32'(det_valid), 1);
    check("t2_range", 32'(det_range), 61);
    check("t2_peak", 32'(det_peak), 300);
    det_ready = 1'b1; send(0); det_ready = 1'b0;

    // 3: nine runs with the consumer stalled
    trig_pulse(100);
    for (int k = 0; k < 9; k++) begin
      idle_to(100 + 10 * k);
      send(200 + k); send(200 + k);
    end
    idle_to(190);
    check("t3_ovf_set", 32'(overflow), 1);
    check("t3_head", 32'(det_range), 100);
    trig_pulse(100);
    check("t3_ovf_clr", 32'(overflow), 0);
    check("t3_kept", 32'(det_valid), 1);
    det_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_v%0d", k), 32'(det_valid), 1);
      check($sformatf("t3_r%0d", k), 32'(det_range), 32'(100 + 10 * k));
      check($sformatf("t3_p%0d", k), 32'(det_peak), 32'(200 + k));
      send(0);
    end
    det_ready = 1'b0;
    check("t3_drained", 32'(det_valid), 0);

    // 4: run straddling the last range sample
    idle_to(4094);
    send(500); send(500);
    check("t4_done", 32'(sweep_done), 1);
    check("t4_lat1", 32'(det_valid), 0);
    send(3000);
    check("t4_valid", 32'(det_valid), 1);
    check("t4_range", 32'(det_range), 4094);
    check("t4_peak", 32'(det_peak), 500);
    det_ready = 1'b1; send(3000); det_ready = 1'b0;
    repeat (5) send(3000);
    check("t4_ignored", 32'(det_valid), 0);
    check("t4_done_hold", 32'(sweep_done), 1);

    // 5: trig mid-run discards it; range restarts at 0
    trig_pulse(100);
    check("t5_done_clr", 32'(sweep_done), 0);
    idle_to(298);
    send(500); send(500);
    trig = 1'b1; vid_in = DATA_W'(500); tick(); trig = 1'b0; cur = 0;
    send(0); send(0); send(0);
    check("t5_discard", 32'(det_valid), 0);
    idle_to(5);
    send(500); send(500); send(0); send(0);
    check("t5_restart_v", 32'(det_valid), 1);
    check("t5_restart_r", 32'(det_range), 5);
    #2; rst = 1'b1; #1;
    check("t5_rst_valid", 32'(det_valid), 0);
    check("t5_rst_range", 32'(det_range), 0);
    check("t5_rst_peak", 32'(det_peak), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("t5_empty", 32'(det_valid), 0);
    check("t5_idle", 32'(sweep_done), 0);

    // 6: long run saturates width, short run reports its length
    trig_pulse(100);
    idle_to(10);
    repeat (20) send(500);
    send(0); send(0);
    check("t6_long_r", 32'(det_range), 10);
`ifdef STC_DET_WIDTH_EN
    check("t6_long_w", 32'(det_width), 15);
`endif
    det_ready = 1'b1; send(0); det_ready = 1'b0;
    idle_to(40);
    send(300); send(400); send(400); send(0); send(0);
    check("t6_short_v", 32'(det_valid), 1);
    check("t6_short_r", 32'(det_range), 41);
    check("t6_short_p", 32'(det_peak), 400);
`ifdef STC_DET_WIDTH_EN
    check("t6_short_w", 32'(det_width), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
